// File: rtl/wb_writer_if.sv
// -----------------------------------------------------------------------------
// wb_writer_if
//   Bundles every signal of the writeback stage other than clock and reset.
//   The MEM-stage handshake, the data-memory read response and the
//   register-file write port all live here.
//
//   Signals (direction as seen by the writeback stage):
//     mem_valid    in   MEM stage presents an instruction
//     mem_ready    out  writer can accept an instruction this cycle
//     mem_wreg     in   instruction writes a GPR
//     mem_waddr    in   destination GPR
//     mem_wdata    in   ALU result (non-load)
//     mem_is_load  in   instruction is a load
//     mem_load_op  in   000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW
//     mem_addr_lo  in   effective address bits [1:0]
//     flush        in   kill the accepting instruction and any pending load
//     dmem_rvalid  in   data-memory read response valid
//     dmem_rdata   in   read data, big-endian lanes (byte 0 = [31:24])
//     stall_req    out  pipeline hold while a load is outstanding
//     we/waddr/wdata out register-file write port (registered)
//     err/err_code out one-cycle error pulse and its cause
//
//   Modports: slave = the writeback stage, master = whatever drives it.
// -----------------------------------------------------------------------------
interface wb_writer_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic        flush;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic [1:0]  err_code;

    modport slave (
        input  mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
               mem_load_op, mem_addr_lo, flush, dmem_rvalid, dmem_rdata,
        output mem_ready, stall_req, we, waddr, wdata, err, err_code
    );

    modport master (
        output mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
               mem_load_op, mem_addr_lo, flush, dmem_rvalid, dmem_rdata,
        input  mem_ready, stall_req, we, waddr, wdata, err, err_code
    );
endinterface

// File: rtl/wb_writer.sv
// -----------------------------------------------------------------------------
// wb_writer
//   Writeback stage of the MIPS pipeline. It accepts one retiring instruction
//   per cycle from the MEM stage. ALU results reach the register file one
//   registered cycle later. A load parks the stage in WAIT_LOAD until the
//   data memory answers. The returned word then has its byte or halfword
//   extracted (big-endian lanes) and extended before it is written. A
//   watchdog bounds the wait and reports a timeout error.
//
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  synchronous reset, active-high
//     bus   wb_writer_if.slave: MEM handshake, dmem response, RF write port,
//           error pulse
//
//   Parameters:
//     TMO_W  width of the load-wait watchdog. A timeout fires once the counter
//            has reached 2^TMO_W-1 with no response.
// -----------------------------------------------------------------------------
module wb_writer #(
    parameter int TMO_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    wb_writer_if.slave     bus
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [TMO_W-1:0] WDOG_MAX = '1;

    // FSM state
    state_e            state_q, state_d;

    // Context of the single outstanding load
    logic              ld_wreg_q,  ld_wreg_d;
    logic [4:0]        ld_waddr_q, ld_waddr_d;
    logic [2:0]        ld_op_q,    ld_op_d;
    logic [1:0]        ld_lo_q,    ld_lo_d;
    logic [TMO_W-1:0]  wdog_q,     wdog_d;

    // Registered outputs
    logic              we_q,       we_d;
    logic [4:0]        waddr_q,    waddr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              err_q,      err_d;
    logic [1:0]        err_code_q, err_code_d;

    // Decode of the instruction presented by MEM
    logic              accept;
    logic              op_illegal;
    logic              misaligned;
    logic              wdog_expired;
    logic [31:0]       load_result;

    // Big-endian lane extraction followed by sign or zero extension.
    function automatic logic [31:0] extract_load(
        input logic [2:0]  op,
        input logic [1:0]  lo,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (lo)
            2'b00:   byte_v = word[31:24];
            2'b01:   byte_v = word[23:16];
            2'b10:   byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        // Only even addresses reach here for halfwords, so bit 1 picks the lane.
        half_v = lo[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   extract_load = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  extract_load = {24'h0, byte_v};
            OP_LH:   extract_load = {{16{half_v[15]}}, half_v};
            OP_LHU:  extract_load = {16'h0, half_v};
            default: extract_load = word;
        endcase
    endfunction

    assign accept       = bus.mem_valid && (state_q == IDLE) && !bus.flush && !rst;
    // 101/110/111 are the only encodings outside LB..LW.
    assign op_illegal   = bus.mem_load_op[2] && (bus.mem_load_op[1:0] != 2'b00);
    assign wdog_expired = (wdog_q == WDOG_MAX);
    assign load_result  = extract_load(ld_op_q, ld_lo_q, bus.dmem_rdata);

    always_comb begin
        case (bus.mem_load_op)
            OP_LH, OP_LHU: misaligned = bus.mem_addr_lo[0];
            OP_LW:         misaligned = (bus.mem_addr_lo != 2'b00);
            default:       misaligned = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_wreg_q  <= 1'b0;
            ld_waddr_q <= 5'd0;
            ld_op_q    <= 3'd0;
            ld_lo_q    <= 2'd0;
            wdog_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            ld_wreg_q  <= ld_wreg_d;
            ld_waddr_q <= ld_waddr_d;
            ld_op_q    <= ld_op_d;
            ld_lo_q    <= ld_lo_d;
            wdog_q     <= wdog_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && bus.mem_is_load && !op_illegal && !misaligned)
                    state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                // Flush, a response or the watchdog all end the wait.
                if (bus.flush || bus.dmem_rvalid || wdog_expired)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output and datapath logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. Any path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        we_d       = 1'b0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        ld_wreg_d  = ld_wreg_q;
        ld_waddr_d = ld_waddr_q;
        ld_op_d    = ld_op_q;
        ld_lo_d    = ld_lo_q;
        wdog_d     = wdog_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.mem_is_load) begin
                        // GPR 0 is hard-wired to zero and is never written.
                        we_d    = bus.mem_wreg && (bus.mem_waddr != 5'd0);
                        waddr_d = bus.mem_waddr;
                        wdata_d = bus.mem_wdata;
                    end else if (op_illegal) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end else if (misaligned) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        ld_wreg_d  = bus.mem_wreg;
                        ld_waddr_d = bus.mem_waddr;
                        ld_op_d    = bus.mem_load_op;
                        ld_lo_d    = bus.mem_addr_lo;
                        wdog_d     = '0;
                    end
                end
            end
            WAIT_LOAD: begin
                // Priority: flush, then response, then timeout.
                if (bus.flush) begin
                    wdog_d = '0;
                end else if (bus.dmem_rvalid) begin
                    we_d    = ld_wreg_q && (ld_waddr_q != 5'd0);
                    waddr_d = ld_waddr_q;
                    wdata_d = load_result;
                end else if (wdog_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_ready = (state_q == IDLE);
    assign bus.stall_req = (state_q == WAIT_LOAD);
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_wb_writer.sv
// -----------------------------------------------------------------------------
// tb_wb_writer
//   Self-checking bench for wb_writer (TMO_W = 3). It covers a table of
//   single-instruction vectors, hand-written multi-cycle corner cases, and a
//   randomized stream scored against a behavioural model.
// -----------------------------------------------------------------------------
module tb_wb_writer;
    localparam int TMO_W     = 3;
    localparam int TMO_LIMIT = (1 << TMO_W) - 1;
    localparam int NV        = 18;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_writer_if bus();

    wb_writer #(.TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_valid   = 1'b0;
        bus.mem_wreg    = 1'b0;
        bus.mem_waddr   = 5'd0;
        bus.mem_wdata   = 32'd0;
        bus.mem_is_load = 1'b0;
        bus.mem_load_op = 3'd0;
        bus.mem_addr_lo = 2'd0;
        bus.flush       = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
    endtask

    task automatic drive_xfer(input bit is_load, input bit wreg, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic [2:0] op, input logic [1:0] lo);
        idle_inputs();
        bus.mem_valid   = 1'b1;
        bus.mem_is_load = is_load;
        bus.mem_wreg    = wreg;
        bus.mem_waddr   = waddr;
        bus.mem_wdata   = wdata;
        bus.mem_load_op = op;
        bus.mem_addr_lo = lo;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [31:0] ref_extract(input int op, input int lo, input logic [31:0] w);
        int unsigned byte_v;
        int unsigned half_v;
        byte_v = (w >> (8 * (3 - lo))) & 32'hFF;
        half_v = (w >> ((lo >= 2) ? 0 : 16)) & 32'hFFFF;
        case (op)
            0:       return (byte_v >= 128) ? byte_v - 32'd256 : byte_v;
            1:       return byte_v;
            2:       return (half_v >= 32768) ? half_v - 32'd65536 : half_v;
            3:       return half_v;
            default: return w;
        endcase
    endfunction

    bit          m_pending;
    int          m_waited;
    bit          m_wreg;
    int          m_waddr;
    int          m_op;
    int          m_lo;
    bit          e_we;
    bit          e_err;
    logic [1:0]  e_code;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    // Applies the rules for one clock edge using the inputs now on the bus.
    task automatic model_edge();
        int size;
        e_we   = 1'b0;
        e_err  = 1'b0;
        e_code = 2'd0;
        if (rst) begin
            m_pending = 1'b0;
            e_waddr   = 5'd0;
            e_wdata   = 32'd0;
            return;
        end
        if (m_pending) begin
            if (bus.flush) begin
                m_pending = 1'b0;
            end else if (bus.dmem_rvalid) begin
                m_pending = 1'b0;
                e_we      = m_wreg && (m_waddr != 0);
                e_waddr   = 5'(m_waddr);
                e_wdata   = ref_extract(m_op, m_lo, bus.dmem_rdata);
            end else if (m_waited == TMO_LIMIT) begin
                m_pending = 1'b0;
                e_err     = 1'b1;
                e_code    = 2'b10;
            end else begin
                m_waited++;
            end
        end else if (bus.mem_valid && !bus.flush) begin
            size = (bus.mem_load_op == 3'd4) ? 4 : ((bus.mem_load_op >= 3'd2) ? 2 : 1);
            if (!bus.mem_is_load) begin
                e_we    = bus.mem_wreg && (bus.mem_waddr != 5'd0);
                e_waddr = bus.mem_waddr;
                e_wdata = bus.mem_wdata;
            end else if (bus.mem_load_op > 3'd4) begin
                e_err  = 1'b1;
                e_code = 2'b11;
            end else if ((int'(bus.mem_addr_lo) % size) != 0) begin
                e_err  = 1'b1;
                e_code = 2'b01;
            end else begin
                m_pending = 1'b1;
                m_waited  = 0;
                m_wreg    = bus.mem_wreg;
                m_waddr   = int'(bus.mem_waddr);
                m_op      = int'(bus.mem_load_op);
                m_lo      = int'(bus.mem_addr_lo);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_load;
        bit          wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic [31:0] rdata;
        int          lat;
        bit          x_we;
        logic [31:0] x_wdata;
        bit          x_err;
        logic [1:0]  x_code;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'h1234_5678, 3'd0, 2'd0, 32'h0,          0, 1'b1, 32'h1234_5678, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'd6,  32'hDEAD_BEEF, 3'd0, 2'd0, 32'h0,          0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'h5555_AAAA, 3'd0, 2'd0, 32'h0,          0, 1'b0, 32'h0,         1'b0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 5'd7,  32'h0BAD_F00D, 3'd0, 2'd0, 32'h0,          0, 1'b0, 32'h0,         1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 5'd8,  32'h0,         3'd0, 2'd1, 32'h1180_2233,  1, 1'b1, 32'hFFFF_FF80, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 5'd9,  32'h0,         3'd1, 2'd1, 32'h1180_2233,  3, 1'b1, 32'h0000_0080, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 5'd10, 32'h0,         3'd2, 2'd2, 32'h0000_8001,  2, 1'b1, 32'hFFFF_8001, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 1'b1, 5'd11, 32'h0,         3'd3, 2'd0, 32'h8001_0000,  1, 1'b1, 32'h0000_8001, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b1, 5'd12, 32'h0,         3'd4, 2'd0, 32'hCAFE_F00D,  5, 1'b1, 32'hCAFE_F00D, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b1, 5'd13, 32'h0,         3'd0, 2'd3, 32'h0000_007F,  1, 1'b1, 32'h0000_007F, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 1'b1, 5'd14, 32'h0,         3'd1, 2'd2, 32'h0000_AB00,  2, 1'b1, 32'h0000_00AB, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 1'b1, 5'd15, 32'h0,         3'd0, 2'd0, 32'h9A00_0000,  8, 1'b1, 32'hFFFF_FF9A, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 5'd16, 32'h0,         3'd4, 2'd2, 32'h0,          0, 1'b0, 32'h0,         1'b1, 2'b01};
        vecs[13] = '{1'b1, 1'b1, 5'd17, 32'h0,         3'd2, 2'd1, 32'h0,          0, 1'b0, 32'h0,         1'b1, 2'b01};
        vecs[14] = '{1'b1, 1'b1, 5'd18, 32'h0,         3'd3, 2'd3, 32'h0,          0, 1'b0, 32'h0,         1'b1, 2'b01};
        vecs[15] = '{1'b1, 1'b1, 5'd19, 32'h0,         3'd7, 2'd0, 32'h0,          0, 1'b0, 32'h0,         1'b1, 2'b11};
        vecs[16] = '{1'b1, 1'b1, 5'd20, 32'h0,         3'd5, 2'd0, 32'h0,          0, 1'b0, 32'h0,         1'b1, 2'b11};
        vecs[17] = '{1'b1, 1'b1, 5'd0,  32'h0,         3'd4, 2'd0, 32'h1357_9BDF,  2, 1'b0, 32'h0,         1'b0, 2'd0};

        idle_inputs();

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        check("rst_we",       bus.we,        1'b0);
        check("rst_waddr",    bus.waddr,     5'd0);
        check("rst_wdata",    bus.wdata,     32'd0);
        check("rst_err",      bus.err,       1'b0);
        check("rst_code",     bus.err_code,  2'd0);
        check("rst_ready",    bus.mem_ready, 1'b1);
        check("rst_stall",    bus.stall_req, 1'b0);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NV; i++) begin
            drive_xfer(vecs[i].is_load, vecs[i].wreg, vecs[i].waddr, vecs[i].wdata,
                       vecs[i].op, vecs[i].lo);
            tick();
            idle_inputs();
            if (vecs[i].is_load && !vecs[i].x_err) begin
                check($sformatf("vec%0d_accept_stall", i), bus.stall_req, 1'b1);
                check($sformatf("vec%0d_accept_we", i),    bus.we,        1'b0);
                for (int k = 1; k < vecs[i].lat; k++) begin
                    tick();
                    check($sformatf("vec%0d_wait_stall", i), bus.stall_req, 1'b1);
                end
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = vecs[i].rdata;
                tick();
                idle_inputs();
            end
            check($sformatf("vec%0d_we", i),    bus.we,        vecs[i].x_we);
            check($sformatf("vec%0d_err", i),   bus.err,       vecs[i].x_err);
            check($sformatf("vec%0d_ready", i), bus.mem_ready, 1'b1);
            if (vecs[i].x_we) begin
                check($sformatf("vec%0d_waddr", i), bus.waddr, vecs[i].waddr);
                check($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].x_wdata);
            end
            if (vecs[i].x_err)
                check($sformatf("vec%0d_code", i), bus.err_code, vecs[i].x_code);
        end

        // ---------------- back-to-back ALU writes ----------------
        drive_xfer(1'b0, 1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        tick();
        check("b2b_we1",    bus.we,    1'b1);
        check("b2b_waddr1", bus.waddr, 5'd5);
        check("b2b_wdata1", bus.wdata, 32'h1234_5678);
        drive_xfer(1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, 3'd0, 2'd0);
        tick();
        check("b2b_we2",    bus.we,    1'b1);
        check("b2b_waddr2", bus.waddr, 5'd6);
        check("b2b_wdata2", bus.wdata, 32'hDEAD_BEEF);
        idle_inputs();
        tick();
        check("b2b_we_off", bus.we, 1'b0);

        // ---------------- watchdog timeout then late response ----------------
        drive_xfer(1'b1, 1'b1, 5'd21, 32'h0, 3'd4, 2'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < TMO_LIMIT; k++) begin
            tick();
            check("tmo_wait_stall", bus.stall_req, 1'b1);
            check("tmo_wait_err",   bus.err,       1'b0);
        end
        tick();
        check("tmo_err",   bus.err,       1'b1);
        check("tmo_code",  bus.err_code,  2'b10);
        check("tmo_we",    bus.we,        1'b0);
        check("tmo_ready", bus.mem_ready, 1'b1);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hFFFF_0000;
        tick();
        idle_inputs();
        check("late_rvalid_we",  bus.we,  1'b0);
        check("late_rvalid_err", bus.err, 1'b0);

        // ---------------- response in the timeout cycle wins ----------------
        drive_xfer(1'b1, 1'b1, 5'd22, 32'h0, 3'd4, 2'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < TMO_LIMIT; k++) tick();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h0102_0304;
        tick();
        idle_inputs();
        check("edge_rvalid_we",    bus.we,    1'b1);
        check("edge_rvalid_err",   bus.err,   1'b0);
        check("edge_rvalid_wdata", bus.wdata, 32'h0102_0304);

        // ---------------- flush beats rvalid while waiting ----------------
        drive_xfer(1'b1, 1'b1, 5'd23, 32'h0, 3'd4, 2'd0);
        tick();
        idle_inputs();
        bus.flush       = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h7777_7777;
        tick();
        idle_inputs();
        check("flush_we",    bus.we,        1'b0);
        check("flush_err",   bus.err,       1'b0);
        check("flush_ready", bus.mem_ready, 1'b1);

        // ---------------- flush with mem_valid in IDLE ----------------
        drive_xfer(1'b0, 1'b1, 5'd24, 32'h2468_ACE0, 3'd0, 2'd0);
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_idle_we",    bus.we,        1'b0);
        check("flush_idle_ready", bus.mem_ready, 1'b1);

        // ---------------- reset mid-load ----------------
        drive_xfer(1'b1, 1'b1, 5'd25, 32'h0, 3'd4, 2'd0);
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", bus.mem_ready, 1'b1);
        check("rst_mid_wdata", bus.wdata,     32'd0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hABCD_EF01;
        tick();
        idle_inputs();
        check("rst_mid_we",    bus.we,        1'b0);
        check("rst_mid_waddr", bus.waddr,     5'd0);
        check("rst_mid_wdata2", bus.wdata,    32'd0);
        check("rst_mid_err",   bus.err,       1'b0);
        check("rst_mid_code",  bus.err_code,  2'd0);
        check("rst_mid_stall", bus.stall_req, 1'b0);

        // ---------------- randomized stream against the model ----------------
        rst = 1'b1;
        tick();
        m_pending = 1'b0;
        m_waited  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.mem_valid   = ($urandom_range(0, 3) != 0);
            bus.mem_wreg    = ($urandom_range(0, 7) != 0);
            bus.mem_waddr   = 5'($urandom_range(0, 31));
            bus.mem_wdata   = $urandom;
            bus.mem_is_load = 1'($urandom_range(0, 1));
            bus.mem_load_op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                        : 3'($urandom_range(5, 7));
            bus.mem_addr_lo = 2'($urandom_range(0, 3));
            bus.flush       = ($urandom_range(0, 15) == 0);
            bus.dmem_rvalid = ($urandom_range(0, 5) == 0);
            bus.dmem_rdata  = $urandom;
            model_edge();
            tick();
            check("rnd_we",    bus.we,        e_we);
            check("rnd_err",   bus.err,       e_err);
            check("rnd_ready", bus.mem_ready, !m_pending);
            check("rnd_stall", bus.stall_req, m_pending);
            if (e_err)
                check("rnd_code", bus.err_code, e_code);
            if (e_we || rst) begin
                check("rnd_waddr", bus.waddr, e_waddr);
                check("rnd_wdata", bus.wdata, e_wdata);
            end
        end
        rst = 1'b0;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback stage of the MIPS pipeline. Sits between the MEM stage and the register-file write port (we/waddr/wdata).
- Accepts one retiring instruction per cycle. ALU results are written after one registered cycle.
- Loads wait for a variable-latency data-memory response, then the returned data is byte/halfword-extracted and sign/zero-extended before writing.
- Holds the pipeline while a load is outstanding. A watchdog bounds that wait.

Parameters:
- TMO_W, 8, width of the load-wait watchdog counter. Timeout fires when the counter reaches 2^TMO_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  writer can accept (combinational: state==IDLE)
- mem_wreg  in  1  instruction writes a GPR
- mem_waddr  in  5  destination GPR
- mem_wdata  in  32  ALU result (non-load)
- mem_is_load  in  1  instruction is a load
- mem_load_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW
- mem_addr_lo  in  2  effective address bits [1:0]
- flush  in  1  kill the accepting instruction and any pending load
- dmem_rvalid  in  1  data memory read response valid
- dmem_rdata  in  32  read data, big-endian lanes (byte 0 = [31:24])
- stall_req  out  1  combinational: state==WAIT_LOAD
- we  out  1  register-file write enable (registered)
- waddr  out  5  register-file write address (registered)
- wdata  out  32  register-file write data (registered)
- err  out  1  one-cycle error pulse (registered)
- err_code  out  2  01 misaligned, 10 timeout, 11 illegal load_op (valid with err)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; we=0, waddr=0, wdata=0, err=0, err_code=0, watchdog=0.
  - Any pending load is discarded. No write is ever produced for it.
- Accept: a transfer occurs when mem_valid && mem_ready && !flush && !rst.
- FSM, IDLE:
  - Transfer with !mem_is_load: next cycle we=mem_wreg && (mem_waddr!=0), waddr=mem_waddr, wdata=mem_wdata. Stay IDLE. One-cycle latency; back-to-back transfers give back-to-back writes.
  - Transfer with mem_is_load:
    - Illegal op (101/110/111): next cycle err=1, err_code=11, we=0, stay IDLE.
    - Misaligned (LH/LHU with addr_lo[0]=1, LW with addr_lo!=00): next cycle err=1, err_code=01, we=0, stay IDLE.
    - Otherwise: latch waddr, wreg, op, addr_lo; clear watchdog; go WAIT_LOAD; we=0 next cycle.
  - No transfer: we=0 next cycle.
  - dmem_rvalid while IDLE is ignored.
- FSM, WAIT_LOAD (mem_ready=0, stall_req=1):
  - flush: go IDLE, no write, no err. Flush has priority over rvalid in the same cycle.
  - dmem_rvalid: next cycle we=wreg && (waddr!=0), wdata=extracted data. Go IDLE.
  - Else the watchdog increments. Once it has reached 2^TMO_W-1 with no rvalid, the next cycle gives err=1, err_code=10, we=0, and the FSM goes IDLE.
  - dmem_rvalid in the timeout cycle wins over the timeout.
  - The earliest response is the cycle after accept. Response latency is therefore >=1 cycle.
- Extraction (big-endian):
  - Byte select: addr_lo 00 selects [31:24], 01 [23:16], 10 [15:8], 11 [7:0].
  - Halfword select: addr_lo 00 selects [31:16], 10 selects [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Ordering and pulses:
  - Writes to GPR 0 never assert we.
  - Writes always emerge in accept order; there is only one outstanding load.
  - err and we are never asserted in the same cycle.
  - Each is a single-cycle pulse unless a new event occurs the next cycle.

Test Plan:
- Reset then ALU stream: accept (waddr=5, wdata=0x1234_5678, wreg=1) and then (waddr=6, wdata=0xDEAD_BEEF) on consecutive cycles -> we=1 two consecutive cycles with those values, 1 cycle after each accept; waddr=0 case -> we=0.
- Load extraction: LB addr_lo=01, rdata=0x1180_2233 -> wdata=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr_lo=10, rdata=0x0000_8001 -> 0xFFFF_8001. LW -> rdata unchanged. Each write occurs the cycle after rvalid, with stall_req=1 while waiting.
- Misaligned/illegal: LW addr_lo=10 -> err=1, err_code=01, we=0, mem_ready stays 1. load_op=111 -> err_code=11.
- Timeout, TMO_W=3: load accepted, no rvalid -> the watchdog reaches 7 and err=1, err_code=10 is asserted the next cycle, then IDLE. A late rvalid afterwards -> ignored, no write.
- Flush: load pending, flush and rvalid in the same cycle -> no write, no err, mem_ready=1 next cycle. flush with mem_valid in IDLE -> no write.
- Reset mid-load: rst=1 in WAIT_LOAD, rvalid the next cycle -> we stays 0, all outputs 0, state IDLE.
